// File: rtl/uart_rx_engine.sv
// UART receive engine: oversampled start detect, mid-bit sampling, LSB-first
// deserialisation, optional parity, 1/2 stop bits, valid/ready output register.
module uart_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic HAS_PARITY = (PARITY_EN != 0);
  localparam logic ODD_PARITY = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 full_pt;
  logic                 done;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops a true 2-stage shift.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: done is a combinational strobe so the output register loads on the
  // same edge as the last stop sample; continuous assigns cannot infer latches.
  assign full_pt = baud_tick && (tick_cnt == TICK_LAST);
  assign done    = (state == S_STOP) && full_pt && (bit_cnt == LAST_STOP);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tick_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: if (baud_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            state    <= rx_s ? S_IDLE : S_DATA;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_DATA: if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_PARITY: if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            perr     <= ((^shreg) ^ rx_s) != ODD_PARITY;
            state    <= S_STOP;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_STOP: if (baud_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            if (!rx_s) ferr <= 1'b1;
            // Leaving at mid stop bit gives half a bit of margin for the next start edge.
            if (bit_cnt == LAST_STOP) state <= S_IDLE;
            else                      bit_cnt <= bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output holding register: a new word may replace the old one only if the
  // old one is gone or being accepted on this very edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= HAS_PARITY ? perr : 1'b0;
          frame_err  <= ferr | ~rx_s;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: four parameterisations driven by one
// serial line each, expected words and flags hand-computed per frame.
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       baud_tick = 1'b0;
  logic [3:0] rx_line = 4'hF;
  logic [3:0] ready = 4'h0;
  logic [7:0] data0, data1, data2;
  logic [4:0] data3;
  logic [3:0] valid, perr, ferr, ovr, busy;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // One baud_tick every 4 clocks, changed on the falling edge.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  uart_rx_engine u0 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_line[0]), .rx_ready(ready[0]),
    .rx_data(data0), .rx_valid(valid[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun(ovr[0]), .busy(busy[0]));

  uart_rx_engine #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_line[1]), .rx_ready(ready[1]),
    .rx_data(data1), .rx_valid(valid[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun(ovr[1]), .busy(busy[1]));

  uart_rx_engine #(.STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_line[2]), .rx_ready(ready[2]),
    .rx_data(data2), .rx_valid(valid[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun(ovr[2]), .busy(busy[2]));

  uart_rx_engine #(.DATA_BITS(5), .OVERSAMPLE(8)) u3 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx_line[3]), .rx_ready(ready[3]),
    .rx_data(data3), .rx_valid(valid[3]), .parity_err(perr[3]), .frame_err(ferr[3]),
    .overrun(ovr[3]), .busy(busy[3]));

  // Returns on the rising edge of the n-th baud_tick from now.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  // Drives a frame up to one clock before the receiver's last stop sample:
  // the next rising edge is the completion edge.
  task automatic send_head(input int w, input logic [8:0] d, input int nb, input int os,
                           input bit par_en, input logic pbit, input int nstop,
                           input logic s1, input logic s2);
    wait_ticks(1);
    #1 rx_line[w] = 1'b0;
    wait_ticks(os);
    for (int j = 0; j < nb; j++) begin
      #1 rx_line[w] = d[j];
      wait_ticks(os);
    end
    if (par_en) begin
      #1 rx_line[w] = pbit;
      wait_ticks(os);
    end
    if (nstop == 2) begin
      #1 rx_line[w] = s1;
      wait_ticks(os);
    end
    #1 rx_line[w] = (nstop == 2) ? s2 : s1;
    wait_ticks(os / 2 - 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tail(input int w, input int os);
    rx_line[w] = 1'b1;
    wait_ticks(os / 2);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (valid !== 4'h0) begin bad++; $display("FAIL reset_valid got=%b want=0000", valid); end
    total++; if (perr !== 4'h0 || ferr !== 4'h0) begin bad++; $display("FAIL reset_flags got=%b/%b want=0000/0000", perr, ferr); end
    total++; if (ovr !== 4'h0 || busy !== 4'h0) begin bad++; $display("FAIL reset_ovr_busy got=%b/%b want=0000/0000", ovr, busy); end
    total++; if (data0 !== 8'h00 || data3 !== 5'h00) begin bad++; $display("FAIL reset_data got=%h/%h want=00/00", data0, data3); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    ready[0] = 1'b1;
    send_head(0, 9'h0A5, 8, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%b want=0", valid[0]); end
    step_edge();
    total++; if (valid[0] !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", valid[0]); end
    total++; if (data0 !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", data0); end
    total++; if (perr[0] !== 1'b0 || ferr[0] !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b want=00", perr[0], ferr[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b want=0", busy[0]); end
    step_edge();
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL basic_accept got=%b want=0", valid[0]); end
    total++; if (data0 !== 8'hA5) begin bad++; $display("FAIL basic_data_kept got=%h want=a5", data0); end
    send_tail(0, 16);
  endtask

  task automatic test_glitch();
    wait_ticks(1);
    #1 rx_line[0] = 1'b0;
    wait_ticks(4);
    #1 rx_line[0] = 1'b1;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL glitch_busy_start got=%b want=1", busy[0]); end
    wait_ticks(3);
    #1;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL glitch_busy_tick7 got=%b want=1", busy[0]); end
    wait_ticks(1);
    #1;
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL glitch_busy_mid got=%b want=0", busy[0]); end
    wait_ticks(16);
    #1;
    total++; if (valid[0] !== 1'b0 || perr[0] !== 1'b0 || ferr[0] !== 1'b0 || ovr[0] !== 1'b0) begin
      bad++; $display("FAIL glitch_quiet got=v%b p%b f%b o%b want=all 0", valid[0], perr[0], ferr[0], ovr[0]);
    end
  endtask

  task automatic test_parity();
    logic [7:0] pd [4] = '{8'h0F, 8'h0F, 8'h07, 8'h07};
    logic       pb [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       pe [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    ready[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_head(1, {1'b0, pd[k]}, 8, 16, 1'b1, pb[k], 1, 1'b1, 1'b1);
      step_edge();
      total++; if (valid[1] !== 1'b1 || data1 !== pd[k]) begin bad++; $display("FAIL parity_data%0d got=v%b %h want=v1 %h", k, valid[1], data1, pd[k]); end
      total++; if (perr[1] !== pe[k] || ferr[1] !== 1'b0) begin bad++; $display("FAIL parity_flag%0d got=p%b f%b want=p%b f0", k, perr[1], ferr[1], pe[k]); end
      send_tail(1, 16);
    end
  endtask

  task automatic test_two_stop();
    logic [7:0] sd  [3] = '{8'h3C, 8'h55, 8'h99};
    logic       st1 [3] = '{1'b1, 1'b1, 1'b0};
    logic       st2 [3] = '{1'b0, 1'b1, 1'b1};
    logic       fe  [3] = '{1'b1, 1'b0, 1'b1};
    ready[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_head(2, {1'b0, sd[k]}, 8, 16, 1'b0, 1'b0, 2, st1[k], st2[k]);
      step_edge();
      total++; if (valid[2] !== 1'b1 || data2 !== sd[k]) begin bad++; $display("FAIL stop2_data%0d got=v%b %h want=v1 %h", k, valid[2], data2, sd[k]); end
      total++; if (ferr[2] !== fe[k] || perr[2] !== 1'b0) begin bad++; $display("FAIL stop2_flag%0d got=f%b p%b want=f%b p0", k, ferr[2], perr[2], fe[k]); end
      send_tail(2, 16);
      wait_ticks(16);
    end
  endtask

  task automatic test_back_to_back();
    ready[0] = 1'b0;
    send_head(0, 9'h011, 8, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    step_edge();
    total++; if (valid[0] !== 1'b1 || data0 !== 8'h11) begin bad++; $display("FAIL b2b_first got=v%b %h want=v1 11", valid[0], data0); end
    send_tail(0, 16);
    send_head(0, 9'h022, 8, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    step_edge();
    total++; if (ovr[0] !== 1'b1) begin bad++; $display("FAIL b2b_overrun got=%b want=1", ovr[0]); end
    total++; if (valid[0] !== 1'b1 || data0 !== 8'h11) begin bad++; $display("FAIL b2b_held got=v%b %h want=v1 11", valid[0], data0); end
    step_edge();
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL b2b_overrun_pulse got=%b want=0", ovr[0]); end
    send_tail(0, 16);
    send_head(0, 9'h022, 8, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    ready[0] = 1'b1;
    step_edge();
    total++; if (valid[0] !== 1'b1 || data0 !== 8'h22) begin bad++; $display("FAIL b2b_swap got=v%b %h want=v1 22", valid[0], data0); end
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL b2b_swap_ovr got=%b want=0", ovr[0]); end
    step_edge();
    total++; if (valid[0] !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", valid[0]); end
    send_tail(0, 16);
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'h77;
    ready[0] = 1'b1;
    wait_ticks(1);
    #1 rx_line[0] = 1'b0;
    wait_ticks(16);
    for (int j = 0; j < 3; j++) begin
      #1 rx_line[0] = d[j];
      wait_ticks(16);
    end
    #1;
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before got=%b want=1", busy[0]); end
    reset = 1'b1;
    rx_line[0] = 1'b1;
    step_edge();
    reset = 1'b0;
    total++; if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || ovr[0] !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=v%b b%b o%b want=000", valid[0], busy[0], ovr[0]); end
    total++; if (data0 !== 8'h00 || perr[0] !== 1'b0 || ferr[0] !== 1'b0) begin bad++; $display("FAIL rstmid_data got=%h p%b f%b want=00 p0 f0", data0, perr[0], ferr[0]); end
    wait_ticks(16);
    #1;
    total++; if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=v%b b%b want=00", valid[0], busy[0]); end
    send_head(0, 9'h081, 8, 16, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    step_edge();
    total++; if (valid[0] !== 1'b1 || data0 !== 8'h81 || ferr[0] !== 1'b0) begin bad++; $display("FAIL rstmid_next got=v%b %h f%b want=v1 81 f0", valid[0], data0, ferr[0]); end
    send_tail(0, 16);
  endtask

  task automatic test_small();
    ready[3] = 1'b1;
    send_head(3, 9'h015, 5, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    total++; if (valid[3] !== 1'b0) begin bad++; $display("FAIL small_pre_valid got=%b want=0", valid[3]); end
    step_edge();
    total++; if (valid[3] !== 1'b1 || data3 !== 5'h15) begin bad++; $display("FAIL small_data got=v%b %h want=v1 15", valid[3], data3); end
    total++; if (perr[3] !== 1'b0 || ferr[3] !== 1'b0 || busy[3] !== 1'b0) begin bad++; $display("FAIL small_flags got=p%b f%b b%b want=000", perr[3], ferr[3], busy[3]); end
    step_edge();
    total++; if (valid[3] !== 1'b0) begin bad++; $display("FAIL small_accept got=%b want=0", valid[3]); end
    send_tail(3, 8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_two_stop();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
